// File: rtl/fifo_write_packer.sv
// fifo_write_packer: byte-to-word packer feeding the write port of the
// dual-clock data FIFO. Runs entirely in the FIFO write-clock domain.
//
// A start pulse latches a block length in bytes. Bytes arrive over a
// valid/ready handshake and are packed into DATA_WIDTH-bit words. Each word
// is pushed to the FIFO while fifo_full is low. The last partial word of a
// block is zero-padded. block_done pulses once the block is complete.
//
// Optional build macro PACKER_MSB_FIRST_EN:
//   defined   - the first byte of a word lands in the most significant lane and
//               lanes fill downward, so padding occupies the low lanes.
//   undefined - little-endian lane order, with the first byte in bits [7:0].

module fifo_write_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_BITS   = 12
) (
  input  logic                  write_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_BITS-1:0]   block_len,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  write_enable,
  output logic                  busy,
  output logic                  block_done,
  output logic [LEN_BITS-1:0]   word_count
);

  // Bytes per word, derived from the word width.
  localparam int BPW    = DATA_WIDTH / 8;
  localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BPW - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_PUSH    = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Bit offset of a logical lane inside the packing register. The logical
  // lane counts bytes in arrival order. The physical placement depends on the
  // configured lane order.
  function automatic int lane_base(input logic [LANE_W-1:0] idx);
`ifdef PACKER_MSB_FIRST_EN
    lane_base = (BPW - 1 - int'(idx)) * 8;
`else
    lane_base = int'(idx) * 8;
`endif
  endfunction

  logic [1:0]            state_q,      state_d;
  logic [LANE_W-1:0]     lane_idx_q,   lane_idx_d;
  logic [LEN_BITS-1:0]   bytes_left_q, bytes_left_d;
  logic [DATA_WIDTH-1:0] pack_q,       pack_d;
  logic [DATA_WIDTH-1:0] data_q,       data_d;
  logic                  we_q,         we_d;
  logic [LEN_BITS-1:0]   word_count_q, word_count_d;
  logic                  ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  handshake_s;

  // A byte is consumed only while the packer advertises ready, which is only
  // in COLLECT. byte_valid is therefore ignored in every other state.
  assign handshake_s = byte_valid & ready_q;

  // Next-state logic for the FSM, the packing register and the write port.
  always_comb begin
    state_d      = state_q;
    lane_idx_d   = lane_idx_q;
    bytes_left_d = bytes_left_q;
    pack_d       = pack_q;
    data_d       = data_q;
    we_d         = 1'b0;
    word_count_d = word_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bytes_left_d = block_len;
          lane_idx_d   = {LANE_W{1'b0}};
          pack_d       = {DATA_WIDTH{1'b0}};
          word_count_d = {LEN_BITS{1'b0}};
          if (block_len == {LEN_BITS{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_COLLECT: begin
        if (handshake_s) begin
          pack_d[lane_base(lane_idx_q) +: 8] = byte_in;
          lane_idx_d   = lane_idx_q + LANE_W'(1'b1);
          bytes_left_d = bytes_left_q - LEN_BITS'(1'b1);
          // The word is complete when the top lane was filled or the block ran out.
          if ((lane_idx_q == LAST_LANE) || (bytes_left_q == LEN_BITS'(1'b1))) begin
            state_d = ST_PUSH;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_PUSH: begin
        if (fifo_full) begin
          // Hold the finished word until the FIFO has room.
          state_d = ST_PUSH;
        end else begin
          data_d       = pack_q;
          we_d         = 1'b1;
          word_count_d = word_count_q + LEN_BITS'(1'b1);
          lane_idx_d   = {LANE_W{1'b0}};
          pack_d       = {DATA_WIDTH{1'b0}};
          if (bytes_left_q == {LEN_BITS{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered output flags. Reset is asynchronous and
  // discards any partial word.
  always_ff @(posedge write_clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lane_idx_q   <= {LANE_W{1'b0}};
      bytes_left_q <= {LEN_BITS{1'b0}};
      pack_q       <= {DATA_WIDTH{1'b0}};
      data_q       <= {DATA_WIDTH{1'b0}};
      we_q         <= 1'b0;
      word_count_q <= {LEN_BITS{1'b0}};
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_idx_q   <= lane_idx_d;
      bytes_left_q <= bytes_left_d;
      pack_q       <= pack_d;
      data_q       <= data_d;
      we_q         <= we_d;
      word_count_q <= word_count_d;
      // Status flags are decoded from the next state so they leave flops cleanly.
      ready_q      <= (state_d == ST_COLLECT);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_d == ST_DONE);
    end
  end

  assign byte_ready   = ready_q;
  assign data         = data_q;
  assign write_enable = we_q;
  assign busy         = busy_q;
  assign block_done   = done_q;
  assign word_count   = word_count_q;

endmodule
